timer_irq_ctrl: RTL and testbench
=================================

TIMER_IRQ_CTRL -- requirements
Module: timer_irq_ctrl

Interface
REQ-001 Parameter NUM_SRC, default 12, number of timer interrupt sources.
REQ-002 Parameter VEC_WIDTH, default 4, width of vector output; SHALL satisfy 2**VEC_WIDTH >= NUM_SRC.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 irq_src  input  NUM_SRC  level sources: [3:0]=CMIA0..3, [7:4]=CMIB0..3, [11:8]=OVI0..3.
REQ-006 irq_mask  input  NUM_SRC  per-source enable, 1=enabled.
REQ-007 irq  output  1  interrupt request to CPU.
REQ-008 irq_vec  output  VEC_WIDTH  index of granted source, valid while irq=1.
REQ-009 irq_ack  input  1  CPU acknowledge, single-cycle pulse.
REQ-010 pending  output  NUM_SRC  latched pending flags, masked and unmasked.
REQ-011 overrun  output  1  one-cycle pulse: new edge on a source whose pending bit is already set.

Function
REQ-012 Rising-edge detect per source: edge[i] = irq_src[i] & ~src_q[i]; src_q registered every cycle.
REQ-013 pending[i] SHALL set at the clock edge where edge[i]=1, regardless of irq_mask[i].
REQ-014 pending[i] SHALL clear only on irq_ack in state REQ with irq_vec==i; simultaneous set and clear -> set wins, pending stays 1.
REQ-015 FSM states IDLE, ARB, REQ.
REQ-016 IDLE: if |(pending & irq_mask) -> ARB, else stay.
REQ-017 ARB: pick winner among pending & irq_mask, register into irq_vec -> REQ; if set became empty (mask dropped) -> IDLE.
REQ-018 REQ: irq=1, irq_vec held stable; on irq_ack -> clear granted pending bit, irq=0 next cycle, -> IDLE.
REQ-019 Latency: edge sampled at clock k -> irq=1 after clock k+2; back-to-back grants separated by 2 cycles with irq=0 (IDLE, ARB).
REQ-020 Mask changes while in REQ SHALL NOT withdraw the request; grant held until acked.
REQ-021 irq_ack outside REQ SHALL be ignored (no state or pending change).
REQ-022 overrun asserts one cycle when edge[i] & pending[i] (before clear) for any i, except when pending[i] is cleared by ack in the same cycle.
REQ-023 Default arbitration: fixed priority, lowest index wins (CMIA0 highest, OVI3 lowest).

Reset
REQ-024 rst=1 asynchronously forces state=IDLE, pending=0, src_q=0, irq=0, irq_vec=0, overrun=0, round-robin pointer=0.
REQ-025 Reset mid-REQ SHALL drop irq immediately; sources high at reset release produce edges only after going low and high again is NOT required: src_q=0 means a level held high yields an edge on first clock after release.

Configuration
REQ-026 Macro TIMER_IRQ_RR_EN defined: round-robin arbitration; search starts at (last granted index + 1) mod NUM_SRC, pointer updated on ack.
REQ-027 Macro undefined: fixed priority per REQ-023; no pointer register exists.

Structure
REQ-028 Shared package timer_pkg holds FSM state typedef (IDLE/ARB/REQ), source index constants (CMIA0..OVI3), NUM_SRC default.
REQ-029 One sub-module irq_prio_arb: combinational priority encoder with start-pointer input (tied 0 in fixed mode), outputs found flag and index.

Verification
REQ-030 Reset, then irq_src[0] 0->1 at clock 5, mask all 1 -> irq=1, irq_vec=0 after clock 7; ack at clock 9 -> pending[0]=0, irq=0 after clock 9.
REQ-031 irq_src[4] and irq_src[8] rise same cycle, fixed mode -> grant 4 first, ack, then grant 8 two cycles later.
REQ-032 irq_mask[1]=0, pulse irq_src[1] -> pending[1]=1, irq stays 0; set mask[1]=1 -> irq, irq_vec=1 two cycles later.
REQ-033 TIMER_IRQ_RR_EN: sources 0 and 3 re-pulsed after every ack -> grants alternate 0,3,0,3.
REQ-034 Second edge on source 2 while pending[2]=1 and not granted -> overrun one cycle, pending[2] stays 1, one grant only.
REQ-035 rst asserted while irq=1 -> irq=0, pending=0 without clock; ack after release ignored.

Source files
------------

// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared types and constants for the timer interrupt controller
//
// Purpose : FSM state encoding, timer source index map and default sizing,
//           imported by every file of the timer_irq_ctrl slice.
// Ports   : none (package).

package timer_pkg;

  localparam int NUM_SRC_DEF   = 12;
  localparam int VEC_WIDTH_DEF = 4;

  // Source index map: compare-match A, compare-match B, overflow, four channels each.
  localparam int CMIA0 = 0;
  localparam int CMIA1 = 1;
  localparam int CMIA2 = 2;
  localparam int CMIA3 = 3;
  localparam int CMIB0 = 4;
  localparam int CMIB1 = 5;
  localparam int CMIB2 = 6;
  localparam int CMIB3 = 7;
  localparam int OVI0  = 8;
  localparam int OVI1  = 9;
  localparam int OVI2  = 10;
  localparam int OVI3  = 11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    REQ  = 2'd2
  } state_t;

endpackage

// File: rtl/timer_irq_ctrl_if.sv
// rtl/timer_irq_ctrl_if.sv - CPU-side interrupt request/acknowledge bundle
//
// Purpose : groups the request, granted vector and acknowledge between the
//           interrupt controller (master) and the CPU (slave).
// Signals : irq     - interrupt request, held until acknowledged
//           irq_vec - index of the granted source, valid while irq=1
//           irq_ack - single-cycle acknowledge pulse from the CPU

interface timer_irq_ctrl_if #(
  parameter int VEC_WIDTH = 4
);

  logic                 irq;
  logic [VEC_WIDTH-1:0] irq_vec;
  logic                 irq_ack;

  modport master (
    output irq,
    output irq_vec,
    input  irq_ack
  );

  modport slave (
    input  irq,
    input  irq_vec,
    output irq_ack
  );

endinterface

// File: rtl/irq_prio_arb.sv
// rtl/irq_prio_arb.sv - combinational priority encoder with rotating start point
//
// Purpose : returns the first requesting index at or above start_i, wrapping
//           to the lowest requesting index when nothing at/above start_i asks.
//           With start_i=0 this is plain lowest-index-wins priority.
// Ports   : req_i   - request vector
//           start_i - index where the search begins
//           found_o - at least one request present
//           idx_o   - winning index (0 when found_o=0)

module irq_prio_arb #(
  parameter int NUM_SRC   = 12,
  parameter int VEC_WIDTH = 4
) (
  input  logic [NUM_SRC-1:0]   req_i,
  input  logic [VEC_WIDTH-1:0] start_i,
  output logic                 found_o,
  output logic [VEC_WIDTH-1:0] idx_o
);

  logic                 hi_found;
  logic [VEC_WIDTH-1:0] hi_idx;
  logic [VEC_WIDTH-1:0] lo_idx;

  // Descending scan: the last hit written is the lowest index. lo_idx tracks
  // the overall lowest request (the wrap-around winner), hi_idx the lowest one
  // at or above the start point.
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        lo_idx = VEC_WIDTH'(i);
        if (i >= int'(start_i)) begin
          hi_found = 1'b1;
          hi_idx   = VEC_WIDTH'(i);
        end
      end
    end
  end

  assign found_o = |req_i;
  assign idx_o   = hi_found ? hi_idx : lo_idx;

endmodule

// File: rtl/timer_irq_ctrl.sv
// rtl/timer_irq_ctrl.sv - timer interrupt controller: edge latch, arbitration, CPU handshake
//
// Purpose : latches rising edges of the timer interrupt sources into pending
//           flags, arbitrates among enabled pending sources and presents one
//           grant at a time to the CPU until it is acknowledged.
// Config  : TIMER_IRQ_RR_EN defined   -> round-robin arbitration, search starts
//                                        after the last acknowledged source
//           TIMER_IRQ_RR_EN undefined -> fixed priority, lowest index wins
// Ports   : clk        - clock, all state on rising edge
//           rst        - asynchronous active-high reset
//           irq_src_i  - level interrupt sources
//           irq_mask_i - per-source enable (1 = enabled)
//           pending_o  - latched pending flags, irrespective of mask
//           overrun_o  - one-cycle pulse: edge on an already-pending source
//           cpu        - irq / irq_vec / irq_ack handshake (master side)

module timer_irq_ctrl
  import timer_pkg::*;
#(
  parameter int NUM_SRC   = NUM_SRC_DEF,
  parameter int VEC_WIDTH = VEC_WIDTH_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_SRC-1:0]  irq_src_i,
  input  logic [NUM_SRC-1:0]  irq_mask_i,
  output logic [NUM_SRC-1:0]  pending_o,
  output logic                overrun_o,
  timer_irq_ctrl_if.master    cpu
);

  state_t               state_q;
  logic [NUM_SRC-1:0]   src_q;
  logic [NUM_SRC-1:0]   pending_q;
  logic [NUM_SRC-1:0]   pending_d;
  logic                 overrun_q;
  logic                 overrun_d;
  logic                 irq_q;
  logic [VEC_WIDTH-1:0] vec_q;

  logic [NUM_SRC-1:0]   rise;
  logic [NUM_SRC-1:0]   ack_clr;
  logic                 ack_fire;
  logic [NUM_SRC-1:0]   arb_req;
  logic                 arb_found;
  logic [VEC_WIDTH-1:0] arb_idx;
  logic [VEC_WIDTH-1:0] arb_start;

  assign rise     = irq_src_i & ~src_q;
  assign ack_fire = (state_q == REQ) && cpu.irq_ack;
  assign arb_req  = pending_q & irq_mask_i;

  // Only an acknowledge of a live grant clears anything; a stray ack is a no-op.
  always_comb begin
    ack_clr = '0;
    if (ack_fire) begin
      ack_clr[vec_q] = 1'b1;
    end
  end

  // OR-ing the new edges in after the clear makes a same-cycle re-edge win.
  // Such a re-edge is not an overrun because the earlier event was just served.
  assign pending_d = (pending_q & ~ack_clr) | rise;
  assign overrun_d = |(rise & pending_q & ~ack_clr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_q     <= '0;
      pending_q <= '0;
      overrun_q <= 1'b0;
    end else begin
      src_q     <= irq_src_i;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
    end
  end

`ifdef TIMER_IRQ_RR_EN
  logic [VEC_WIDTH-1:0] ptr_q;
  assign arb_start = ptr_q;
`else
  assign arb_start = '0;
`endif

  irq_prio_arb #(
    .NUM_SRC   (NUM_SRC),
    .VEC_WIDTH (VEC_WIDTH)
  ) u_arb (
    .req_i   (arb_req),
    .start_i (arb_start),
    .found_o (arb_found),
    .idx_o   (arb_idx)
  );

  // Grant FSM. irq and irq_vec are registered here so they only change on
  // state transitions; the mask is not consulted in REQ, so a granted request
  // survives the mask being dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      irq_q   <= 1'b0;
      vec_q   <= '0;
`ifdef TIMER_IRQ_RR_EN
      ptr_q   <= '0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (|arb_req) begin
            state_q <= ARB;
          end
        end
        ARB: begin
          // Mask may have dropped the last candidate since IDLE looked.
          if (arb_found) begin
            vec_q   <= arb_idx;
            irq_q   <= 1'b1;
            state_q <= REQ;
          end else begin
            state_q <= IDLE;
          end
        end
        REQ: begin
          if (cpu.irq_ack) begin
            irq_q   <= 1'b0;
            state_q <= IDLE;
`ifdef TIMER_IRQ_RR_EN
            ptr_q   <= (int'(vec_q) == NUM_SRC - 1) ? '0 : vec_q + 1'b1;
`endif
          end
        end
        default: begin
          irq_q   <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign cpu.irq     = irq_q;
  assign cpu.irq_vec = vec_q;
  assign pending_o   = pending_q;
  assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_timer_irq_ctrl.sv
// tb/tb_timer_irq_ctrl.sv - self-checking bench for timer_irq_ctrl

module tb_timer_irq_ctrl;
  import timer_pkg::*;

  logic        clk;
  logic        rst;
  logic [11:0] src;
  logic [11:0] mask;
  logic [11:0] pending;
  logic        overrun;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_q[$];
  logic irq_prev = 1'b0;

  timer_irq_ctrl_if #(.VEC_WIDTH(4)) bus ();

  timer_irq_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .irq_src_i  (src),
    .irq_mask_i (mask),
    .pending_o  (pending),
    .overrun_o  (overrun),
    .cpu        (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Scoreboard: every new grant pops the expected vector pushed by the stimulus.
  always @(posedge clk) begin
    int e;
    #1;
    if (bus.irq === 1'b1 && irq_prev !== 1'b1) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_grant vec=%0d expected none", bus.irq_vec);
        n_fail++;
      end else begin
        e = exp_q.pop_front();
        if (bus.irq_vec !== 4'(e)) begin
          $display("FAIL grant_vec got=%0d expected=%0d", bus.irq_vec, e);
          n_fail++;
        end
      end
    end
    irq_prev = bus.irq;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_ack();
    bus.irq_ack = 1'b1;
    tick();
    bus.irq_ack = 1'b0;
  endtask

  task automatic wait_irq(output bit ok);
    int cyc = 0;
    while (bus.irq !== 1'b1 && cyc < 20) begin
      tick();
      cyc++;
    end
    ok = (bus.irq === 1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    src = '0;
    mask = '1;
    bus.irq_ack = 1'b0;
    tick();
    tick();
    n_tests++;
    if (bus.irq !== 1'b0) begin $display("FAIL reset_irq got=%b expected=0", bus.irq); n_fail++; end
    n_tests++;
    if (bus.irq_vec !== 4'd0) begin $display("FAIL reset_vec got=%0d expected=0", bus.irq_vec); n_fail++; end
    n_tests++;
    if (pending !== 12'h000) begin $display("FAIL reset_pending got=%h expected=000", pending); n_fail++; end
    n_tests++;
    if (overrun !== 1'b0) begin $display("FAIL reset_overrun got=%b expected=0", overrun); n_fail++; end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic_latency();
    exp_q.push_back(CMIA0);
    src[CMIA0] = 1'b1;
    tick();
    n_tests++;
    if (pending[CMIA0] !== 1'b1 || bus.irq !== 1'b0) begin
      $display("FAIL basic_k pending0=%b irq=%b expected 1,0", pending[CMIA0], bus.irq); n_fail++;
    end
    tick();
    n_tests++;
    if (bus.irq !== 1'b0) begin $display("FAIL basic_k1 irq=%b expected=0", bus.irq); n_fail++; end
    tick();
    n_tests++;
    if (bus.irq !== 1'b1) begin $display("FAIL basic_k2 irq=%b expected=1", bus.irq); n_fail++; end
    tick();
    do_ack();
    n_tests++;
    if (bus.irq !== 1'b0 || pending[CMIA0] !== 1'b0) begin
      $display("FAIL basic_ack irq=%b pending0=%b expected 0,0", bus.irq, pending[CMIA0]); n_fail++;
    end
    src[CMIA0] = 1'b0;
    tick();
  endtask

  task automatic test_simultaneous();
    exp_q.push_back(CMIB0);
    exp_q.push_back(OVI0);
    src[CMIB0] = 1'b1;
    src[OVI0]  = 1'b1;
    tick();
    src = '0;
    tick();
    tick();
    n_tests++;
    if (bus.irq !== 1'b1) begin $display("FAIL simul_first irq=%b expected=1", bus.irq); n_fail++; end
    do_ack();
    n_tests++;
    if (bus.irq !== 1'b0) begin $display("FAIL simul_gap1 irq=%b expected=0", bus.irq); n_fail++; end
    tick();
    n_tests++;
    if (bus.irq !== 1'b0) begin $display("FAIL simul_gap2 irq=%b expected=0", bus.irq); n_fail++; end
    tick();
    n_tests++;
    if (bus.irq !== 1'b1) begin $display("FAIL simul_second irq=%b expected=1", bus.irq); n_fail++; end
    do_ack();
    tick();
  endtask

  task automatic test_masked();
    mask[CMIA1] = 1'b0;
    src[CMIA1] = 1'b1;
    tick();
    src[CMIA1] = 1'b0;
    tick();
    tick();
    n_tests++;
    if (pending[CMIA1] !== 1'b1 || bus.irq !== 1'b0) begin
      $display("FAIL masked_hold pending1=%b irq=%b expected 1,0", pending[CMIA1], bus.irq); n_fail++;
    end
    exp_q.push_back(CMIA1);
    mask[CMIA1] = 1'b1;
    tick();
    n_tests++;
    if (bus.irq !== 1'b0) begin $display("FAIL masked_unmask1 irq=%b expected=0", bus.irq); n_fail++; end
    tick();
    n_tests++;
    if (bus.irq !== 1'b1) begin $display("FAIL masked_unmask2 irq=%b expected=1", bus.irq); n_fail++; end
    // Dropping the mask while granted must not withdraw the request.
    mask[CMIA1] = 1'b0;
    tick();
    n_tests++;
    if (bus.irq !== 1'b1 || bus.irq_vec !== 4'd1) begin
      $display("FAIL masked_hold_grant irq=%b vec=%0d expected 1,1", bus.irq, bus.irq_vec); n_fail++;
    end
    do_ack();
    mask = '1;
    tick();
  endtask

  task automatic test_ack_outside();
    mask[CMIB1] = 1'b0;
    src[CMIB1] = 1'b1;
    tick();
    src[CMIB1] = 1'b0;
    tick();
    do_ack();
    tick();
    n_tests++;
    if (pending !== 12'h020 || bus.irq !== 1'b0) begin
      $display("FAIL stray_ack pending=%h irq=%b expected 020,0", pending, bus.irq); n_fail++;
    end
    exp_q.push_back(CMIB1);
    mask[CMIB1] = 1'b1;
    tick();
    tick();
    do_ack();
    tick();
  endtask

  task automatic test_overrun();
    bit ok;
    bit quiet = 1'b1;
    mask[CMIA2] = 1'b0;
    src[CMIA2] = 1'b1;
    tick();
    n_tests++;
    if (overrun !== 1'b0) begin $display("FAIL ovr_first got=%b expected=0", overrun); n_fail++; end
    src[CMIA2] = 1'b0;
    tick();
    src[CMIA2] = 1'b1;
    tick();
    n_tests++;
    if (overrun !== 1'b1 || pending[CMIA2] !== 1'b1) begin
      $display("FAIL ovr_pulse overrun=%b pending2=%b expected 1,1", overrun, pending[CMIA2]); n_fail++;
    end
    src[CMIA2] = 1'b0;
    tick();
    n_tests++;
    if (overrun !== 1'b0) begin $display("FAIL ovr_one_cycle got=%b expected=0", overrun); n_fail++; end
    exp_q.push_back(CMIA2);
    mask[CMIA2] = 1'b1;
    wait_irq(ok);
    n_tests++;
    if (!ok) begin $display("FAIL ovr_grant_timeout irq=%b expected=1", bus.irq); n_fail++; end
    do_ack();
    for (int i = 0; i < 6; i++) begin
      if (bus.irq !== 1'b0) quiet = 1'b0;
      tick();
    end
    n_tests++;
    if (!quiet || pending !== 12'h000) begin
      $display("FAIL ovr_single_grant quiet=%b pending=%h expected 1,000", quiet, pending); n_fail++;
    end
  endtask

  task automatic test_ack_collision();
    bit ok;
    exp_q.push_back(CMIA0);
    src[CMIA0] = 1'b1;
    tick();
    src[CMIA0] = 1'b0;
    wait_irq(ok);
    n_tests++;
    if (!ok) begin $display("FAIL coll_grant_timeout irq=%b expected=1", bus.irq); n_fail++; end
    src[CMIA0] = 1'b1;
    bus.irq_ack = 1'b1;
    tick();
    bus.irq_ack = 1'b0;
    src[CMIA0] = 1'b0;
    n_tests++;
    if (pending[CMIA0] !== 1'b1 || overrun !== 1'b0 || bus.irq !== 1'b0) begin
      $display("FAIL coll_set_wins pending0=%b overrun=%b irq=%b expected 1,0,0",
               pending[CMIA0], overrun, bus.irq); n_fail++;
    end
    exp_q.push_back(CMIA0);
    wait_irq(ok);
    n_tests++;
    if (!ok) begin $display("FAIL coll_regrant_timeout irq=%b expected=1", bus.irq); n_fail++; end
    do_ack();
    tick();
  endtask

  task automatic test_back_to_back();
    bit ok;
    int seq[4];
`ifdef TIMER_IRQ_RR_EN
    seq = '{CMIA0, CMIA3, CMIA0, CMIA3};
`else
    seq = '{CMIA0, CMIA0, CMIA0, CMIA0};
`endif
    foreach (seq[i]) exp_q.push_back(seq[i]);
    src[CMIA0] = 1'b1;
    src[CMIA3] = 1'b1;
    tick();
    src = '0;
    for (int g = 0; g < 4; g++) begin
      int v;
      wait_irq(ok);
      n_tests++;
      if (!ok) begin $display("FAIL b2b_timeout grant=%0d irq=%b expected=1", g, bus.irq); n_fail++; end
      v = int'(bus.irq_vec);
      do_ack();
      if (g < 3) begin
        src[v] = 1'b1;
        tick();
        src[v] = 1'b0;
      end
    end
`ifdef TIMER_IRQ_RR_EN
    exp_q.push_back(CMIA0);
`else
    exp_q.push_back(CMIA3);
`endif
    wait_irq(ok);
    n_tests++;
    if (!ok) begin $display("FAIL b2b_drain_timeout irq=%b expected=1", bus.irq); n_fail++; end
    do_ack();
    tick();
    n_tests++;
    if (pending !== 12'h000) begin $display("FAIL b2b_drained pending=%h expected=000", pending); n_fail++; end
  endtask

  task automatic test_reset_mid_req();
    bit ok;
    exp_q.push_back(CMIB2);
    src[CMIB2] = 1'b1;
    src[CMIB3] = 1'b1;
    tick();
    src[CMIB3] = 1'b0;
    wait_irq(ok);
    n_tests++;
    if (!ok) begin $display("FAIL rst_grant_timeout irq=%b expected=1", bus.irq); n_fail++; end
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if (bus.irq !== 1'b0 || pending !== 12'h000) begin
      $display("FAIL rst_async irq=%b pending=%h expected 0,000", bus.irq, pending); n_fail++;
    end
    #1 rst = 1'b0;
    // src[CMIB2] is still high: the cleared edge register must see a new edge.
    exp_q.push_back(CMIB2);
    bus.irq_ack = 1'b1;
    tick();
    bus.irq_ack = 1'b0;
    n_tests++;
    if (pending !== 12'h040 || bus.irq !== 1'b0) begin
      $display("FAIL rst_release pending=%h irq=%b expected 040,0", pending, bus.irq); n_fail++;
    end
    wait_irq(ok);
    n_tests++;
    if (!ok) begin $display("FAIL rst_regrant_timeout irq=%b expected=1", bus.irq); n_fail++; end
    do_ack();
    src = '0;
    tick();
    tick();
  endtask

  initial begin
    test_reset();
    test_basic_latency();
    test_simultaneous();
    test_masked();
    test_ack_outside();
    test_overrun();
    test_ack_collision();
    test_back_to_back();
    test_reset_mid_req();
    n_tests++;
    if (exp_q.size() != 0) begin
      $display("FAIL scoreboard_leftover got=%0d expected=0", exp_q.size()); n_fail++;
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
